// File: rtl/ifetch_prefetch_queue.sv
// ---------------------------------------------------------------------------
// ifetch_prefetch_queue
//   Instruction-fetch front end for the 5-stage core. Streams sequential words
//   from instruction memory over a req/ack handshake into a small FIFO and
//   presents the head word plus its PC to the IF stage. A redirect flushes the
//   FIFO and restarts fetch at a new address. If a request is still in flight
//   at that moment, its data is dropped when it eventually completes.
//
// Ports
//   clk          in   rising-edge clock
//   rst          in   asynchronous, active-low reset
//   redirect     in   1-cycle pulse: flush and refetch from redirect_pc
//   redirect_pc  in   new word-aligned fetch address
//   consume      in   core takes the head entry this cycle
//   inst_valid   out  head entry present
//   inst         out  head instruction (0 when empty)
//   inst_pc      out  PC of head instruction (0 when empty)
//   mem_req      out  fetch request, held until acked
//   mem_addr     out  fetch address, stable while mem_req is high
//   mem_ack      in   memory returns mem_rdata this cycle
//   mem_rdata    in   fetched word
// ---------------------------------------------------------------------------
module ifetch_prefetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        consume,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DROP = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [31:0]      r_fetch_pc;
  logic [31:0]      r_drop_addr;   // address of the request being discarded
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic [PTR_W:0]   w_count_next;
  logic             w_push;
  logic             w_pop;

  logic [31:0] r_pc_mem   [DEPTH];
  logic [31:0] r_inst_mem [DEPTH];

  // Redirect outranks everything: no push, no pop on that edge.
  assign w_push = (r_state == ST_WAIT) && mem_ack && !redirect;
  assign w_pop  = consume && (r_count != '0) && !redirect;

  always_comb begin
    w_count_next = r_count;
    if (redirect) begin
      w_count_next = '0;
    end else begin
      case ({w_push, w_pop})
        2'b10:   w_count_next = r_count + (PTR_W + 1)'(1);
        2'b01:   w_count_next = r_count - (PTR_W + 1)'(1);
        default: w_count_next = r_count;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (redirect || (r_count < FULL_COUNT)) w_state_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (redirect) begin
          // An un-acked request must still complete; its data is discarded.
          w_state_next = mem_ack ? ST_WAIT : ST_DROP;
        end else if (mem_ack) begin
          w_state_next = (w_count_next < FULL_COUNT) ? ST_WAIT : ST_IDLE;
        end
      end
      ST_DROP: begin
        // FIFO was flushed on entry, so there is always room to fetch again.
        if (mem_ack) w_state_next = ST_WAIT;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    mem_req  = (r_state == ST_WAIT) || (r_state == ST_DROP);
    mem_addr = (r_state == ST_DROP) ? r_drop_addr : r_fetch_pc;
  end

  // Fetch address, pointers and occupancy
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fetch_pc  <= RESET_PC;
      r_drop_addr <= RESET_PC;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
    end else begin
      r_count <= w_count_next;
      if (redirect) begin
        r_fetch_pc <= redirect_pc;
        r_wr_ptr   <= '0;
        r_rd_ptr   <= '0;
        // Keep the original in-flight address when already dropping.
        if ((r_state == ST_WAIT) && !mem_ack) r_drop_addr <= r_fetch_pc;
      end else begin
        if (w_push) begin
          r_wr_ptr   <= r_wr_ptr + PTR_W'(1);
          r_fetch_pc <= r_fetch_pc + 32'd4;   // wraps past 0xFFFFFFFC
        end
        if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
    end
  end

  // Storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_pc_mem[r_wr_ptr]   <= r_fetch_pc;
      r_inst_mem[r_wr_ptr] <= mem_rdata;
    end
  end

  assign inst_valid = (r_count != '0);
  assign inst       = inst_valid ? r_inst_mem[r_rd_ptr] : 32'h0;
  assign inst_pc    = inst_valid ? r_pc_mem[r_rd_ptr]   : 32'h0;

endmodule

// File: tb/tb_ifetch_prefetch_queue.sv
module tb_ifetch_prefetch_queue;

  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0040_0000;

  logic        clk;
  logic        rst;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        consume;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int n_checks = 0;
  int n_errors = 0;

  ifetch_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
    .consume(consume), .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- behavioural model ----------------
  // Queue of {pc, inst}; a request is either idle, outstanding, or outstanding
  // but doomed (its data will be thrown away).
  logic [63:0] q[$];
  logic [31:0] m_fetch_pc;
  logic [31:0] m_drop_addr;
  bit          m_busy;
  bit          m_drop;
  int          n0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      q.delete();
      m_fetch_pc  = RESET_PC;
      m_drop_addr = RESET_PC;
      m_busy      = 0;
      m_drop      = 0;
    end else if (redirect) begin
      q.delete();
      if (m_busy && !mem_ack) begin
        if (!m_drop) m_drop_addr = m_fetch_pc;
        m_drop = 1;
      end else begin
        m_drop = 0;
      end
      m_busy     = 1;
      m_fetch_pc = redirect_pc;
    end else begin
      n0 = q.size();
      if (consume && n0 > 0) void'(q.pop_front());
      if (m_drop) begin
        if (mem_ack) m_drop = 0;
      end else if (m_busy) begin
        if (mem_ack) begin
          q.push_back({m_fetch_pc, mem_rdata});
          m_fetch_pc = m_fetch_pc + 32'd4;
          if (q.size() == DEPTH) m_busy = 0;
        end
      end else if (n0 < DEPTH) begin
        m_busy = 1;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic        e_valid;
    logic [31:0] e_inst;
    logic [31:0] e_pc;
    e_valid = (q.size() != 0);
    e_inst  = e_valid ? q[0][31:0]  : 32'h0;
    e_pc    = e_valid ? q[0][63:32] : 32'h0;
    cmp("mem_req",    {31'b0, mem_req},    {31'b0, m_busy});
    cmp("mem_addr",   mem_addr,            m_drop ? m_drop_addr : m_fetch_pc);
    cmp("inst_valid", {31'b0, inst_valid}, {31'b0, e_valid});
    cmp("inst",       inst,                e_inst);
    cmp("inst_pc",    inst_pc,             e_pc);
  end

  // ---------------- stimulus ----------------
  bit auto_ack;
  bit rand_lat;
  int ack_lat;
  int wcnt;

  task automatic drive_ack();
    if (mem_req) begin
      if (wcnt >= ack_lat) begin
        mem_ack = 1'b1;
        wcnt    = 0;
        if (rand_lat) ack_lat = $urandom_range(0, 3);
      end else begin
        mem_ack = 1'b0;
        wcnt++;
      end
    end else begin
      mem_ack = 1'b0;
      wcnt    = 0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
    mem_rdata = $urandom;
    if (auto_ack) drive_ack();
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL lit_%s at %0t: got %h expected %h", name, $time, act, exp);
    end else begin
      $display("check lit_%s ok: %h", name, act);
    end
  endtask

  initial begin
    rst = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; consume = 1'b0;
    mem_ack = 1'b0; mem_rdata = 32'h0;
    auto_ack = 0; rand_lat = 0; ack_lat = 0; wcnt = 0;

    // T1: reset values, then first cycle after release
    step(); step(); settle();
    lit("rst_req",   {31'b0, mem_req},    32'h0);
    lit("rst_addr",  mem_addr,            RESET_PC);
    lit("rst_valid", {31'b0, inst_valid}, 32'h0);
    lit("rst_inst",  inst,                32'h0);
    lit("rst_pc",    inst_pc,             32'h0);
    step(); rst = 1'b1;
    step(); settle();
    lit("t1_req",  {31'b0, mem_req}, 32'h1);
    lit("t1_addr", mem_addr,         32'h0040_0000);

    // T2: fill with zero-wait memory, no consumption
    mem_ack = 1'b1;
    repeat (4) step();
    settle();
    lit("t2_req",   {31'b0, mem_req},    32'h0);
    lit("t2_valid", {31'b0, inst_valid}, 32'h1);
    lit("t2_pc",    inst_pc,             32'h0040_0000);

    // T3: streaming, consume every cycle
    consume = 1'b1; auto_ack = 1; ack_lat = 0;
    repeat (20) step();

    // T4: slow memory, ack three cycles after request
    ack_lat = 3;
    for (int i = 0; i < 30; i++) begin
      consume = $urandom_range(0, 1);
      step();
    end

    // T5: redirect while a request is in flight
    auto_ack = 0; mem_ack = 1'b0; consume = 1'b0;
    rst = 1'b0;
    step(); rst = 1'b1;
    step();                                // IDLE -> WAIT, no ack
    redirect = 1'b1; redirect_pc = 32'h0040_0100;
    step(); redirect = 1'b0;
    settle();
    lit("t5_drop_req",   {31'b0, mem_req},    32'h1);
    lit("t5_drop_addr",  mem_addr,            32'h0040_0000);
    lit("t5_drop_valid", {31'b0, inst_valid}, 32'h0);
    step();                                // still waiting on the old request
    mem_ack = 1'b1;
    step();                                // old data dropped
    settle();
    lit("t5_new_addr", mem_addr,            32'h0040_0100);
    lit("t5_empty",    {31'b0, inst_valid}, 32'h0);
    step();
    settle();
    lit("t5_valid", {31'b0, inst_valid}, 32'h1);
    lit("t5_pc",    inst_pc,             32'h0040_0100);

    // T6: redirect + ack + consume on the same edge, FIFO nonempty
    consume = 1'b1;
    step();
    settle();
    lit("t6_pre_valid", {31'b0, inst_valid}, 32'h1);
    redirect = 1'b1; redirect_pc = 32'h0040_0300;
    step(); redirect = 1'b0;
    settle();
    lit("t6_valid", {31'b0, inst_valid}, 32'h0);
    lit("t6_req",   {31'b0, mem_req},    32'h1);
    lit("t6_addr",  mem_addr,            32'h0040_0300);
    consume = 1'b0;
    step();
    settle();
    lit("t6_pc", inst_pc, 32'h0040_0300);

    // Address wrap at the top of memory
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    step(); redirect = 1'b0;
    step(); step();
    settle();
    lit("wrap_addr", mem_addr, 32'h0000_0000);
    lit("wrap_pc",   inst_pc,  32'hFFFF_FFF8);

    // Randomized traffic with random latency, redirects and occasional resets
    auto_ack = 1; rand_lat = 1; ack_lat = 1;
    for (int i = 0; i < 3000; i++) begin
      if (!rst) rst = 1'b1;
      else if ($urandom_range(0, 399) == 0) rst = 1'b0;
      consume  = $urandom_range(0, 2) != 0;
      redirect = $urandom_range(0, 11) == 0;
      case ($urandom_range(0, 3))
        0:       redirect_pc = 32'hFFFF_FFF8;
        1:       redirect_pc = 32'h0040_0000;
        default: redirect_pc = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      endcase
      step();
    end
    redirect = 1'b0; consume = 1'b0; rst = 1'b1;
    step(); settle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
